// File: rtl/sync_updown_cnt_param_pkg.sv
// Shared constants and the digit-range helper for the cascaded up/down counter.
// Holds no logic of its own; it is imported by the interface and both modules.
package sync_cnt_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BIN_MAX = 4'hF;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [DIGIT_W-1:0] digit_max(input bit bcd);
    return bcd ? BCD_MAX : BIN_MAX;
  endfunction

endpackage

// File: rtl/sync_updown_cnt_param_if.sv
// Control/data bundle of the cascaded counter: the master drives controls, the
// slave (the counter) returns the count and its wrap strobes.
interface sync_updown_cnt_param_if #(
  parameter int DIGITS = 2
);
  import sync_cnt_pkg::*;

  logic                       en;
  logic                       up;
  logic                       preset;
  logic [DIGIT_W*DIGITS-1:0]  d;
  logic [DIGIT_W*DIGITS-1:0]  q;
  logic                       co;
  logic                       bo;
  logic                       tffout;

  modport master (
    output en, up, preset, d,
    input  q, co, bo, tffout
  );

  modport slave (
    input  en, up, preset, d,
    output q, co, bo, tffout
  );

endinterface

// File: rtl/sync_updown_cnt_param_digit.sv
// One 4-bit up/down digit (binary or BCD) with synchronous load; 1-cycle latency.
// No backpressure: en_in gates counting, carry/borrow feed the next digit's enable.
module updown_digit
  import sync_cnt_pkg::*;
#(
  parameter int BCD = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_in,
  input  logic               up,
  input  logic               preset,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  output logic               carry,
  output logic               borrow
);

  localparam logic [DIGIT_W-1:0] MAX = digit_max(BCD != 0);

  // Out-of-range BCD codes (10..15) roll over on the way up like the max value.
  assign carry  = (q >= MAX);
  assign borrow = (q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!preset) begin
      q <= d;
    end else if (en_in) begin
      if (up) begin
        q <= carry ? '0 : q + 1'b1;
      end else begin
        q <= borrow ? MAX : q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_updown_cnt_param.sv
// Cascaded DIGITS x 4-bit up/down counter with load, CO/BO strobes and a wrap toggle.
// Latency 1 cycle; no backpressure: en gates counting, CO/BO may enable a further stage.
module sync_updown_cnt_param
  import sync_cnt_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BCD    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sync_updown_cnt_param_if.slave   bus
);

  localparam int                  W       = DIGIT_W * DIGITS;
  localparam logic [W-1:0]        ALL_MAX = {DIGITS{digit_max(BCD != 0)}};

  logic [DIGIT_W-1:0] q_dig   [DIGITS];
  logic               carry   [DIGITS];
  logic               borrow  [DIGITS];
  logic [DIGITS:0]    en_chain;
  logic [W-1:0]       q_all;
  logic               all_max;
  logic               all_zero;
  logic               co_int;
  logic               bo_int;
  logic               tff_q;

  assign en_chain[0] = bus.en;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    updown_digit #(
      .BCD (BCD)
    ) u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_in  (en_chain[k]),
      .up     (bus.up),
      .preset (bus.preset),
      .d      (bus.d[k*DIGIT_W +: DIGIT_W]),
      .q      (q_dig[k]),
      .carry  (carry[k]),
      .borrow (borrow[k])
    );

    assign en_chain[k+1] = en_chain[k] & (bus.up ? carry[k] : borrow[k]);
  end

  always_comb begin
    q_all = '0;
    for (int k = 0; k < DIGITS; k++) begin
      q_all[k*DIGIT_W +: DIGIT_W] = q_dig[k];
    end
  end

  assign all_max  = (q_all == ALL_MAX);
  assign all_zero = (q_all == '0);

  // At all-max / all-zero every digit ripples, so the last chain stage equals en;
  // the exact compare keeps invalid BCD digits from faking a wrap.
  assign co_int = bus.preset &  bus.up & en_chain[DIGITS] & all_max;
  assign bo_int = bus.preset & ~bus.up & en_chain[DIGITS] & all_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tff_q <= 1'b0;
    end else if (co_int | bo_int) begin
      tff_q <= ~tff_q;
    end
  end

  assign bus.q      = q_all;
  assign bus.co     = co_int;
  assign bus.bo     = bo_int;
  assign bus.tffout = tff_q;

endmodule

// File: tb/tb_sync_updown_cnt_param.sv
// Directed bench: a binary and a BCD two-digit counter driven side by side from
// a vector table, plus a hand-written asynchronous-reset sequence.
module tb_sync_updown_cnt_param;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sync_updown_cnt_param_if #(.DIGITS(2)) ifb ();
  sync_updown_cnt_param_if #(.DIGITS(2)) ifd ();

  sync_updown_cnt_param #(.DIGITS(2), .BCD(0)) u_bin (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  sync_updown_cnt_param #(.DIGITS(2), .BCD(1)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       up;
    logic       pre;
    logic [7:0] db;
    logic [7:0] dd;
    logic       cob;   // pre-edge strobes, binary
    logic       bob;
    logic [7:0] qb;    // post-edge state, binary
    logic       tb;
    logic       cod;   // pre-edge strobes, BCD
    logic       bod;
    logic [7:0] qd;    // post-edge state, BCD
    logic       td;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic up, input logic pre,
                       input logic [7:0] db, input logic [7:0] dd);
    ifb.en = en; ifb.up = up; ifb.preset = pre; ifb.d = db;
    ifd.en = en; ifd.up = up; ifd.preset = pre; ifd.d = dd;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

    //        en    up    pre   db     dd     cob   bob   qb     tb    cod   bod   qd     td
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'h17, 8'h17, 1'b0, 1'b0, 8'h17, 1'b0, 1'b0, 1'b0, 8'h17, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h18, 1'b0, 1'b0, 1'b0, 8'h18, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h19, 1'b0, 1'b0, 1'b0, 8'h19, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h1A, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'hFE, 8'h98, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h98, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1});
    vq.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1});
    vq.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h98, 1'b0});
    for (int i = 0; i < 5; i++) begin
      vq.push_back('{1'b0, 1'(i % 2 == 0), 1'b1, 8'h00, 8'h00,
                     1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h98, 1'b0});
    end
    vq.push_back('{1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'h0B, 8'h0B, 1'b0, 1'b0, 8'h0B, 1'b0, 1'b0, 1'b0, 8'h0B, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'h0B, 8'h0B, 1'b0, 1'b0, 8'h0B, 1'b0, 1'b0, 1'b0, 8'h0B, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0});
    // Load at all-max: PRESET gates CO, so no toggle on the load edges.
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'hFF, 8'h99, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'hFF, 8'h99, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'h55, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h56, 1'b1, 1'b0, 1'b0, 8'h56, 1'b1});
    vq.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h57, 1'b1, 1'b0, 1'b0, 8'h57, 1'b1});

    // Reset state with EN=0 so BO is also expected low.
    @(negedge clk);
    @(negedge clk);
    check("rst_qb",  ifb.q,      8'h00);
    check("rst_qd",  ifd.q,      8'h00);
    check("rst_tb",  8'(ifb.tffout), 8'h00);
    check("rst_td",  8'(ifd.tffout), 8'h00);
    check("rst_cob", 8'(ifb.co), 8'h00);
    check("rst_bob", 8'(ifb.bo), 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].up, vq[i].pre, vq[i].db, vq[i].dd);
      #1;
      check($sformatf("v%0d_cob", i), 8'(ifb.co), 8'(vq[i].cob));
      check($sformatf("v%0d_bob", i), 8'(ifb.bo), 8'(vq[i].bob));
      check($sformatf("v%0d_cod", i), 8'(ifd.co), 8'(vq[i].cod));
      check($sformatf("v%0d_bod", i), 8'(ifd.bo), 8'(vq[i].bod));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_qb", i), ifb.q, vq[i].qb);
      check($sformatf("v%0d_tb", i), 8'(ifb.tffout), 8'(vq[i].tb));
      check($sformatf("v%0d_qd", i), ifd.q, vq[i].qd);
      check($sformatf("v%0d_td", i), 8'(ifd.tffout), 8'(vq[i].td));
    end

    // Asynchronous reset between edges while counting up from 57.
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_qb", ifb.q, 8'h00);
    check("arst_qd", ifd.q, 8'h00);
    check("arst_tb", 8'(ifb.tffout), 8'h00);
    check("arst_td", 8'(ifd.tffout), 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    #1;
    check("arst_bob", 8'(ifb.bo), 8'h00);
    check("arst_cod", 8'(ifd.co), 8'h00);
    @(posedge clk);
    #1;
    check("arst_hold_qb", ifb.q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("rel_qb", ifb.q, 8'h01);
    check("rel_qd", ifd.q, 8'h01);
    check("rel_tb", 8'(ifb.tffout), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
